// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited requests to a 1-cycle synchronous
// instruction memory, prefetch FIFO toward decode, redirect flush/restart.
module fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 'h100,
  parameter int unsigned     IMEM_AW    = 10,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [XLEN-1:0]    imem_rdata_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    out_instr_o,
  output logic [XLEN-1:0]    out_pc_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  resp_pc_q;
  logic             resp_v_q;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0]  pc_mem    [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occupancy;
  logic             pop;
  logic             push;
  logic             issue;
  logic             unused_target_lsbs;

  assign target             = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_target_lsbs = ^redirect_pc_i[1:0];

  assign out_valid_o = (count != '0);
  assign pop         = out_valid_o & out_ready_i;
  // A response arriving during a redirect belongs to the killed stream.
  assign push        = resp_v_q & ~redirect_i;

  // Buffered plus in-flight entries after this cycle's pop; issuing only
  // below capacity guarantees every returning response finds a free slot.
  assign occupancy = count + CNT_W'(resp_v_q) - CNT_W'(pop);
  assign issue     = occupancy < CNT_W'(FIFO_DEPTH);

  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q[IMEM_AW+1:2];
    if (!rst) begin
      if (redirect_i) begin
        imem_req_o  = 1'b1;
        imem_addr_o = target[IMEM_AW+1:2];
      end else begin
        imem_req_o  = issue;
      end
    end
  end

  assign out_instr_o = out_valid_o ? instr_mem[rd_ptr] : '0;
  assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_v_q  <= 1'b0;
      resp_pc_q <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (redirect_i) begin
      pc_q      <= target + XLEN'(4);
      resp_v_q  <= 1'b1;
      resp_pc_q <= target;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      if (issue) begin
        pc_q      <= pc_q + XLEN'(4);
        resp_pc_q <= pc_q;
      end
      resp_v_q <= issue;
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      wr_ptr   <= wr_ptr + PTR_W'(push);
      rd_ptr   <= rd_ptr + PTR_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem[wr_ptr] <= imem_rdata_i;
      pc_mem[wr_ptr]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing scenarios plus a random
// run, with delivered PCs/instructions checked against a stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  int          reqs;
  int          pops;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h100),
    .IMEM_AW(10),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req),
    .imem_addr_o(imem_addr),
    .imem_rdata_i(imem_rdata),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_instr_o(out_instr),
    .out_pc_o(out_pc)
  );

  function automatic logic [31:0] imem_word(input logic [9:0] a);
    return {6'h15, a, ~a, 6'h2A};
  endfunction

  always @(posedge clk) imem_rdata <= imem_word(imem_addr);

  // Stream model: after reset or a redirect, decode must see the restart PC
  // and then every following word in order; reqs - pops is the number of
  // instructions fetched but not yet delivered.
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 32'h100;
      reqs   = 0;
      pops   = 0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (out_pc !== exp_pc || out_instr !== imem_word(exp_pc[11:2])) begin
          errors++;
          $display("FAIL stream_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                   out_pc, out_instr, exp_pc, imem_word(exp_pc[11:2]));
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect) begin
        exp_pc = redirect_pc & ~32'h3;
        reqs   = 1;
        pops   = 0;
      end else if (imem_req) begin
        reqs++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h4000; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
          errors++;
          $display("FAIL reset_state: valid=%b req=%b pc=%h instr=%h, expected all zero",
                   out_valid, imem_req, out_pc, out_instr);
        end
      end
      cyc();
    end
    rst = 1'b0; redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h040) begin
      errors++;
      $display("FAIL first_request: req=%b addr=%h, expected req=1 addr=040", imem_req, imem_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_c1_valid: got %b, expected 0", out_valid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL first_delivery: valid=%b pc=%h, expected valid=1 pc=00000100", out_valid, out_pc);
    end
    cyc();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_throughput: cycle %0d valid=%b, expected 1", i, out_valid);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL stall_no_request: cycle %0d req=%b, expected 0", i, imem_req);
        end
      end
      cyc();
    end
    checks++;
    if (reqs - pops != 4 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_buffered: outstanding=%0d valid=%b, expected 4 and 1", reqs - pops, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || (i == 0 && imem_req !== 1'b1)) begin
        errors++;
        $display("FAIL resume_stream: cycle %0d valid=%b req=%b, expected 1 1", i, out_valid, imem_req);
      end
      cyc();
    end
  endtask

  task automatic test_redirect_full();
    out_ready = 1'b0;
    cyc();
    cyc();
    redirect = 1'b1; redirect_pc = 32'h2000;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
      errors++;
      $display("FAIL redirect_request: req=%b addr=%h, expected req=1 addr=000", imem_req, imem_addr);
    end
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_t1_valid: got %b, expected 0", out_valid);
    end
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h2000) begin
      errors++;
      $display("FAIL redirect_t2: valid=%b pc=%h, expected valid=1 pc=00002000", out_valid, out_pc);
    end
    cyc();
    for (int i = 0; i < 4; i++) cyc();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h300;
    cyc();
    redirect_pc = 32'h500;
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_t2_valid: got %b, expected 0", out_valid);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h500) begin
      errors++;
      $display("FAIL b2b_t3: valid=%b pc=%h, expected valid=1 pc=00000500", out_valid, out_pc);
    end
    cyc();
    for (int i = 0; i < 3; i++) cyc();
  endtask

  task automatic test_redirect_pop_and_rst();
    out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h700;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pop_redirect_handshake: valid=%b, expected 1", out_valid);
    end
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_redirect_t1: valid=%b, expected 0", out_valid);
    end
    cyc();
    for (int i = 0; i < 3; i++) cyc();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h900;
    cyc();
    rst = 1'b0; redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h040) begin
      errors++;
      $display("FAIL rst_redirect_restart: req=%b addr=%h, expected req=1 addr=040", imem_req, imem_addr);
    end
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL rst_redirect_delivery: valid=%b pc=%h, expected valid=1 pc=00000100", out_valid, out_pc);
    end
    cyc();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first: valid=%b pc=%h, expected valid=1 pc=fffffffc", out_valid, out_pc);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_second: valid=%b pc=%h, expected valid=1 pc=00000000", out_valid, out_pc);
    end
    cyc();
    redirect = 1'b1; redirect_pc = 32'h1003;
    cyc();
    redirect = 1'b0;
    cyc();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h1000) begin
      errors++;
      $display("FAIL misaligned_target: valid=%b pc=%h, expected valid=1 pc=00001000", out_valid, out_pc);
    end
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      out_ready   = ($urandom_range(0, 9) < 7);
      cyc();
      checks++;
      if (reqs - pops > 4 || reqs - pops < 0) begin
        errors++;
        $display("FAIL random_credit: outstanding=%0d, expected 0..4", reqs - pops);
      end
    end
    rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    test_reset();
    test_backpressure();
    test_redirect_full();
    test_back_to_back();
    test_redirect_pop_and_rst();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with a prefetch FIFO and a valid/ready handshake to decode. It replaces the single-register fetch stage. It drives an external synchronous instruction memory with fixed 1-cycle read latency, so the memory array is no longer part of the stage. Redirects from the branch unit kill in-flight and buffered instructions and restart fetch at the target.

## Interface
- `XLEN`, 32: PC and instruction width.
- `RESET_PC`, 'h100: fetch address after reset.
- `IMEM_AW`, 10: instruction-memory word-address width.
- `FIFO_DEPTH`, 4: prefetch entries; must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `redirect_i`  in  1  branch taken / redirect request.
- `redirect_pc_i`  in  XLEN  redirect target; bits [1:0] ignored.
- `imem_req_o`  out  1  memory read enable.
- `imem_addr_o`  out  IMEM_AW  word address, equal to `fetch_pc[IMEM_AW+1:2]`.
- `imem_rdata_i`  in  XLEN  read data, valid the cycle after `imem_req_o`.
- `out_valid_o`  out  1  instruction available to decode.
- `out_ready_i`  in  1  decode accepts.
- `out_instr_o`  out  XLEN  instruction at the FIFO head.
- `out_pc_o`  out  XLEN  PC of `out_instr_o`.

## Operation
- **State**
  - `pc_q`: next sequential fetch PC.
  - `resp_v_q`, `resp_pc_q`: in-flight request tag.
  - FIFO of {instr, pc}, `FIFO_DEPTH` entries, with `count`.
- **Priority:** `rst` > `redirect_i` > normal fetch.
- **Pop:** `pop = out_valid_o & out_ready_i`. `out_valid_o` is the FIFO not-empty flag, taken from registered state only.
- **Credit:** `issue = (count + resp_v_q - pop) < FIFO_DEPTH`. The in-flight response therefore always has a slot when it returns.
- **Normal cycle**
  - If `issue` is true: `imem_req_o=1`, address taken from `pc_q`, `resp_pc_q<=pc_q`, `pc_q<=pc_q+4`.
  - `resp_v_q<=issue`.
  - If `resp_v_q` is set: push {`imem_rdata_i`, `resp_pc_q`}.
  - Push and pop may occur in the same cycle; `count` is unchanged.
- **Redirect cycle**
  - FIFO flushed (`count<=0`). The response arriving this cycle is discarded, with no push.
  - `imem_req_o=1` with address taken from the target (`redirect_pc_i` with bits [1:0] cleared), regardless of credit.
  - `resp_v_q<=1`, `resp_pc_q<=target`, `pc_q<=target+4`.
  - A pop handshake in this cycle still completes at the interface. Decode owns killing that instruction. The FIFO is emptied regardless.
- **Arithmetic:** PC arithmetic is modulo 2^XLEN, so `'hFFFF_FFFC+4` wraps to 0. Address bits above `IMEM_AW+1` are not sent to memory, which aliases the memory contents.
- **Full FIFO / backpressure:** requests stop. No entry is ever overwritten or dropped. Order is strictly by PC issue order.
- **Empty FIFO:** `out_valid_o=0`. `out_instr_o`/`out_pc_o` are don't-care.

## Timing
- **Reset values** (during and after a `rst` cycle):
  - `out_valid_o=0`, `imem_req_o=0` (gated by `rst`).
  - `pc_q=RESET_PC`, `resp_v_q=0`, FIFO empty.
  - `out_instr_o`, `out_pc_o` = 0.
- **Reset mid-operation:** all state discarded; any `redirect_i` in that cycle is ignored.
- **First fetch**
  - First cycle with `rst=0` (C0): request at `RESET_PC`.
  - C1: data pushed.
  - C2: `out_valid_o=1`, `out_pc_o=RESET_PC`.
- **Redirect latency:** redirect in cycle T gives `out_valid_o=1` with `out_pc_o=target` in T+2. `out_valid_o=0` in T+1.
- **Throughput:** one instruction per cycle sustained while `out_ready_i=1`, for any `FIFO_DEPTH≥2`.
- **Back-to-back redirects** (T and T+1): only the T+1 target is delivered, in T+3.
- **Combinational paths:** `out_ready_i`→`imem_req_o` (via `pop`) and `redirect_i`→`imem_req_o/addr`. There is no combinational path to `out_valid_o`.

## Test plan
- **Reset release:** hold `rst` 3 cycles, then release with `out_ready_i=1` → `imem_addr_o='h40` in C0; `out_valid_o` rises in C2 with `out_pc_o='h100`; following PCs 'h104, 'h108… one per cycle.
- **Backpressure** (`FIFO_DEPTH=4`): stream, then `out_ready_i=0` for 10 cycles → exactly 4 entries buffered, `imem_req_o=0` once credit is exhausted; on re-assert, PCs continue contiguously with no gap or duplicate.
- **Redirect with full FIFO and a request in flight:** target 'h2000 → no old PC appears after T; `out_pc_o='h2000` in T+2, then 'h2004.
- **Redirect on consecutive cycles:** 'h300 then 'h500 → 'h300 never delivered; 'h500 valid in T+3.
- **Redirect coinciding with pop and with `rst`:** with pop, the FIFO empties and T+1 has `out_valid_o=0`; with `rst` high, the redirect is ignored and fetch restarts at 'h100.
- **Wrap:** redirect to 'hFFFF_FFFC → delivered PCs are 'hFFFF_FFFC then 'h0000_0000. A misaligned target 'h1003 is fetched as 'h1000.
